alu_issue_ctrl: RTL

- Initiator side of the ALU interface: accepts ALU operations over a valid/ready handshake and reads both operands from an internal register file.
- Drives a/b/funct to an external combinational ALU and waits a programmable number of cycles.
- Writes the result back to the register file and updates a flag register from ov/cc/cs.
- Sits between the instruction/decode front end and the existing 32-bit ALU. It is the sequential controller the combinational datapath lacks.

---
 rtl/alu_issue_pkg.sv | 38 +++
 rtl/alu_issue_ctrl_regfile.sv | 53 +++++
 rtl/alu_issue_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/alu_issue_pkg.sv
// Shared types and helpers for the ALU issue controller.
// Function classes are decoded from funct[4:2]; logic and add each span two codes.
package alu_issue_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    localparam logic [2:0] FC_LOGIC   = 3'b000;  // funct[4:2] = 00x
    localparam logic [2:0] FC_SHIFT   = 3'b010;
    localparam logic [2:0] FC_CMP     = 3'b011;
    localparam logic [2:0] FC_ADD     = 3'b100;  // funct[4:2] = 10x
    localparam logic [2:0] FC_CALC    = 3'b110;
    localparam logic [2:0] FC_ILLEGAL = 3'b111;

    // Collapse funct[4:2] into one class code.
    function automatic logic [2:0] func_class(input logic [2:0] code);
        logic [2:0] cls;
        case (code)
            3'b000, 3'b001: cls = FC_LOGIC;
            3'b010:         cls = FC_SHIFT;
            3'b011:         cls = FC_CMP;
            3'b100, 3'b101: cls = FC_ADD;
            3'b110:         cls = FC_CALC;
            default:        cls = FC_ILLEGAL;
        endcase
        return cls;
    endfunction

    // Logical and shift operations leave the flag register untouched.
    function automatic logic flags_update(input logic [2:0] code);
        logic [2:0] cls;
        cls = func_class(code);
        return (cls != FC_LOGIC) && (cls != FC_SHIFT);
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_regfile.sv
// Register file for the ALU issue controller: two operand read ports, one debug
// read port (all combinational), one synchronous write port, synchronous clear.
// Register 0 always reads 0 and ignores writes.
module alu_regfile #(
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [31:0]   i_wdata,
    input  logic [AW-1:0] i_raddr_a,
    input  logic [AW-1:0] i_raddr_b,
    input  logic [AW-1:0] i_raddr_dbg,
    output logic [31:0]   o_rdata_a,
    output logic [31:0]   o_rdata_b,
    output logic [31:0]   o_rdata_dbg
);

    localparam int DEPTH = 2**AW;

    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] w_raddr [3];
    logic [31:0]   w_rdata [3];

    // Clear everything on reset; otherwise write any register except 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we && (i_waddr != '0)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign w_raddr[0] = i_raddr_a;
    assign w_raddr[1] = i_raddr_b;
    assign w_raddr[2] = i_raddr_dbg;

    // Identical read ports, each forcing address 0 to read zero.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_rd
            assign w_rdata[gi] = (w_raddr[gi] == '0) ? 32'd0 : r_mem[w_raddr[gi]];
        end
    endgenerate

    assign o_rdata_a   = w_rdata[0];
    assign o_rdata_b   = w_rdata[1];
    assign o_rdata_dbg = w_rdata[2];

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: accepts one operation at a time, reads operands from
// the register file, holds them on the external ALU for ALU_LAT cycles, then
// writes the result back and updates the flag register.
// Optional build macro ALU_ISSUE_ILLEGAL_CHK_EN: class 111 suppresses writeback
// and flag update and sets the sticky err output.
module alu_issue_ctrl
    import alu_issue_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter int ALU_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        in_funct,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [REG_AW-1:0] in_rs,
    input  logic [REG_AW-1:0] in_rt,
    output logic [31:0]       alu_a,
    output logic [31:0]       alu_b,
    output logic [5:0]        alu_funct,
    input  logic [31:0]       alu_s,
    input  logic              alu_ov,
    input  logic              alu_cc,
    input  logic              alu_cs,
    output logic              done,
    output logic              flag_ov,
    output logic              flag_cc,
    output logic              flag_cs,
`ifdef ALU_ISSUE_ILLEGAL_CHK_EN
    output logic              err,
`endif
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [31:0]       dbg_data
);

    localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ALU_LAT - 1);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [REG_AW-1:0] r_rd;
    logic [31:0]       r_alu_a;
    logic [31:0]       r_alu_b;
    logic [5:0]        r_funct;
    logic              r_done;
    logic              r_flag_ov;
    logic              r_flag_cc;
    logic              r_flag_cs;

    logic [31:0]       w_rs_data;
    logic [31:0]       w_rt_data;
    logic              w_accept;
    logic              w_wb_cycle;
    logic              w_illegal;
    logic              w_commit;
    logic              w_flag_upd;

    // Ready only in IDLE and never while reset is held.
    assign in_ready   = rst_n && (r_state == IDLE);
    assign w_accept   = in_valid && in_ready;
    assign w_wb_cycle = (r_state == EXEC) && (r_cnt == '0);

`ifdef ALU_ISSUE_ILLEGAL_CHK_EN
    logic r_err;
    assign w_illegal = (func_class(r_funct[4:2]) == FC_ILLEGAL);
    assign err       = r_err;

    // Sticky error: set by any completed undefined-class operation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_wb_cycle && w_illegal) begin
            r_err <= 1'b1;
        end
    end
`else
    assign w_illegal = 1'b0;
`endif

    assign w_commit   = w_wb_cycle && !w_illegal;
    assign w_flag_upd = w_commit && flags_update(r_funct[4:2]);

    alu_regfile #(
        .AW (REG_AW)
    ) u_rf (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_we        (w_commit),
        .i_waddr     (r_rd),
        .i_wdata     (alu_s),
        .i_raddr_a   (in_rs),
        .i_raddr_b   (in_rt),
        .i_raddr_dbg (dbg_addr),
        .o_rdata_a   (w_rs_data),
        .o_rdata_b   (w_rt_data),
        .o_rdata_dbg (dbg_data)
    );

    // Issue FSM: capture operands on accept, count down, commit on cnt==0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_rd      <= '0;
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_funct   <= '0;
            r_done    <= 1'b0;
            r_flag_ov <= 1'b0;
            r_flag_cc <= 1'b0;
            r_flag_cs <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_alu_a <= w_rs_data;
                        r_alu_b <= w_rt_data;
                        r_funct <= in_funct;
                        r_rd    <= in_rd;
                        r_cnt   <= CNT_INIT;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        if (w_flag_upd) begin
                            r_flag_ov <= alu_ov;
                            r_flag_cc <= alu_cc;
                            r_flag_cs <= alu_cs;
                        end
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_funct = r_funct;
    assign done      = r_done;
    assign flag_ov   = r_flag_ov;
    assign flag_cc   = r_flag_cc;
    assign flag_cs   = r_flag_cs;

endmodule
